input_register_bank: RTL and testbench
======================================

# input_register_bank

Multi-lane, parametrised operand input stage for the parallel MAC datapath. It replaces single-lane hold registers with a LANES-wide bank. The bank has per-lane write enables with hold-last-value semantics, an optional broadcast mode, and a DEPTH-stage elastic pipeline with valid/ready handshake toward the MAC array. Each output beat carries a mask of the lanes refreshed in that beat, so downstream logic can tell new operands from held ones.

## Interface
- RP, 16, lane width in bits (≥1)
- LANES, 4, number of operand lanes (≥1)
- DEPTH, 2, pipeline stages between capture and output (≥1)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear of hold values and pipeline
- bcast  input  1  1 = lane 0 of in_data drives every enabled lane
- w_en  input  LANES  per-lane write enable for the current beat
- in_data  input  LANES*RP  lane l at bits [l*RP +: RP]
- in_valid  input  1  upstream beat present
- in_ready  output  1  bank accepts beat this cycle
- out_data  output  LANES*RP  merged operand vector, same packing
- out_upd  output  LANES  w_en mask that produced out_data
- out_valid  output  1  out_data/out_upd valid
- out_ready  input  1  downstream consumes beat

## Operation
- State:
  - hold[LANES] of RP bits
  - stages S[0..DEPTH-1], each holding data, mask and valid bit V[k]
- Accept: acc = in_valid & in_ready.
- Merge on accept, per lane l:
  - new = bcast ? in_data lane 0 : in_data lane l
  - merged[l] = w_en[l] ? new : hold[l]
- On acc: hold <= merged; S[0] <= {merged, w_en}; V[0] <= 1.
  - w_en = 0 on an accepted beat is legal: it re-emits the hold values with out_upd = 0.
- Ready chain (combinational):
  - r[DEPTH] = out_ready; r[k] = !V[k] | r[k+1]
  - in_ready = r[0] & !clr
- Stage advance: for k ≥ 1, when r[k], S[k] <= S[k-1] and V[k] <= V[k-1].
  - Stage 0 when r[0] and no acc: V[0] <= 0.
  - When r[k] is 0, stage k holds.
- Outputs: out_data/out_upd/out_valid = stage DEPTH-1.
- Data is never dropped or duplicated; beat order is preserved.
- clr (priority over everything except rst_n):
  - next edge: hold <= 0, all V <= 0, stage data <= 0
  - in_ready is 0 during clr, so no beat is accepted that cycle
- Simultaneous acc and downstream pop on a full pipeline is legal: throughput is 1 beat/cycle.

## Timing
- Reset values (rst_n low, asynchronous):
  - out_data = 0, out_upd = 0, out_valid = 0
  - hold = 0, all V = 0
  - in_ready = 1 (clr low) as soon as V is cleared
- Latency: a beat accepted at edge t appears on the outputs right after edge t+DEPTH-1. If in_valid is sampled in cycle c, out_valid is high in cycle c+DEPTH, given no stall.
- Capacity: DEPTH beats are stored under backpressure. in_ready drops only when all V = 1 and out_ready = 0.
- The out_ready → in_ready path is combinational through DEPTH stages. This is accepted for DEPTH ≤ 4.
- rst_n asserted mid-stream discards all in-flight beats immediately. First acceptance is possible in the first cycle after release.
- hold updates only on acc. Stalls never change hold.

## Test plan
- Reset (LANES=4, RP=16, DEPTH=2): pulse rst_n low mid-stream → out_valid=0, out_data=0, out_upd=0 immediately, and in_ready=1 after release.
- Full load: in_data lanes {0x0001,0x0002,0x0003,0x0004}, w_en=1111, one valid beat → two cycles later out_valid=1 for one cycle, lanes {0x0001,0x0002,0x0003,0x0004}, out_upd=1111.
- Partial hold: next beat all lanes 0xAAAA, w_en=0101 → out lanes {0xAAAA,0x0002,0xAAAA,0x0004}, out_upd=0101.
- Broadcast: bcast=1, lane0=0x1234, other lanes 0xFFFF, w_en=1110 → out lanes {0xAAAA,0x1234,0x1234,0x1234}.
- Backpressure: out_ready=0, three consecutive beats valued 1, 2, 3 on all lanes → only two accepted, in_ready=0 from the third cycle. Raise out_ready → beats 1, 2, 3 emerge in order, 1 per cycle, none lost.
- Clear mid-flight: two beats in pipeline, clr=1 for one cycle → out_valid=0 next cycle and in_ready=0 during clr. A following beat with lane0=0x0055, w_en=0001 → out lanes {0x0055,0,0,0}.

Source files
------------

// File: rtl/input_register_bank.sv
// Multi-lane operand input bank: per-lane hold registers with optional broadcast,
// feeding a DEPTH-stage elastic valid/ready pipeline toward the MAC array.
module input_register_bank #(
    parameter int RP    = 16,
    parameter int LANES = 4,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  bcast,
    input  logic [LANES-1:0]      w_en,
    input  logic [LANES*RP-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [LANES*RP-1:0]   out_data,
    output logic [LANES-1:0]      out_upd,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int VW = LANES * RP;

    logic [VW-1:0]                 hold;
    logic [DEPTH-1:0][VW-1:0]      stg_data;
    logic [DEPTH-1:0][LANES-1:0]   stg_upd;
    logic [DEPTH-1:0]              stg_vld;
    logic [DEPTH-1:0]              rdy;
    logic [VW-1:0]                 merged;
    logic                          acc;

    function automatic logic [VW-1:0] merge_lanes(
        input logic [VW-1:0]    din,
        input logic [LANES-1:0] en,
        input logic             bc,
        input logic [VW-1:0]    held
    );
        logic [VW-1:0] m;
        m = '0;
        for (int l = 0; l < LANES; l++) begin
            if (en[l])
                m[l*RP +: RP] = bc ? din[RP-1:0] : din[l*RP +: RP];
            else
                m[l*RP +: RP] = held[l*RP +: RP];
        end
        return m;
    endfunction

    // Stage k can take a beat unless it and every stage after it are full
    // while the consumer stalls; written flat to keep the chain loop-free.
    for (genvar k = 0; k < DEPTH; k++) begin : g_rdy
        assign rdy[k] = out_ready | ~(&stg_vld[DEPTH-1:k]);
    end

    assign in_ready = rdy[0] & ~clr;
    assign acc      = in_valid & in_ready;
    assign merged   = merge_lanes(in_data, w_en, bcast, hold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold     <= '0;
            stg_data <= '0;
            stg_upd  <= '0;
            stg_vld  <= '0;
        end else if (clr) begin
            hold     <= '0;
            stg_data <= '0;
            stg_upd  <= '0;
            stg_vld  <= '0;
        end else begin
            // capture stage
            if (acc) begin
                hold        <= merged;
                stg_data[0] <= merged;
                stg_upd[0]  <= w_en;
                stg_vld[0]  <= 1'b1;
            end else if (rdy[0]) begin
                stg_vld[0]  <= 1'b0;
            end
            // elastic stages: advance only where downstream has room
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    stg_data[k] <= stg_data[k-1];
                    stg_upd[k]  <= stg_upd[k-1];
                    stg_vld[k]  <= stg_vld[k-1];
                end
            end
        end
    end

    assign out_data  = stg_data[DEPTH-1];
    assign out_upd   = stg_upd[DEPTH-1];
    assign out_valid = stg_vld[DEPTH-1];

endmodule

// File: tb/tb_input_register_bank.sv
// Bench for input_register_bank: directed scenarios plus random traffic checked
// against a queue-based model of the beat stream.
module tb_input_register_bank;

    localparam int RP    = 16;
    localparam int LANES = 4;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n, clr, bcast, in_valid, out_ready;
    logic [3:0]  w_en;
    logic [63:0] in_data;
    logic        in_ready, out_valid;
    logic [63:0] out_data;
    logic [3:0]  out_upd;

    input_register_bank #(.RP(RP), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bcast(bcast), .w_en(w_en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_upd(out_upd), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  upd;
        int          born;
    } beat_t;

    beat_t       q[$];
    logic [15:0] mh[4];
    int          cyc;
    int          n_checks;
    int          n_fail;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int l = 0; l < 4; l++) mh[l] = '0;
    endtask

    // Entered at posedge+1 or later: checks mid-cycle, then advances the model one edge.
    task automatic step();
        bit          exp_rdy, exp_vld, acc, pop;
        beat_t       b;
        logic [15:0] nv;
        #3;
        exp_rdy = !clr && (q.size() < DEPTH || out_ready);
        exp_vld = (q.size() > 0) && (cyc >= q[0].born + DEPTH - 1);
        check_val("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        check_val("out_valid", {63'd0, out_valid}, {63'd0, exp_vld});
        if (exp_vld) begin
            check_val("out_data", out_data, q[0].data);
            check_val("out_upd", {60'd0, out_upd}, {60'd0, q[0].upd});
        end
        acc = in_valid && exp_rdy;
        pop = exp_vld && out_ready;
        b.data = '0;
        b.upd  = w_en;
        b.born = 0;
        for (int l = 0; l < 4; l++) begin
            nv = bcast ? in_data[15:0] : in_data[l*16 +: 16];
            b.data[l*16 +: 16] = w_en[l] ? nv : mh[l];
        end
        @(posedge clk);
        cyc++;
        if (clr) begin
            model_clear();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                b.born = cyc;
                q.push_back(b);
                for (int l = 0; l < 4; l++) mh[l] = b.data[l*16 +: 16];
            end
        end
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; clr = 1'b0; bcast = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        w_en = '0; in_data = '0;
        model_clear();
        #2;
        check_val("rst_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_data", out_data, 64'd0);
        check_val("rst_upd", {60'd0, out_upd}, 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full load
        in_data = 64'h0004_0003_0002_0001; w_en = 4'hF; in_valid = 1'b1;
        step(); in_valid = 1'b0; step();
        check_val("load_valid", {63'd0, out_valid}, 64'd1);
        check_val("load_data", out_data, 64'h0004_0003_0002_0001);
        check_val("load_upd", {60'd0, out_upd}, 64'hF);

        // Partial hold
        in_data = {4{16'hAAAA}}; w_en = 4'b0101; in_valid = 1'b1;
        step(); in_valid = 1'b0; step();
        check_val("part_data", out_data, 64'h0004_AAAA_0002_AAAA);
        check_val("part_upd", {60'd0, out_upd}, 64'h5);

        // Broadcast
        bcast = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_1234; w_en = 4'b1110; in_valid = 1'b1;
        step(); in_valid = 1'b0; bcast = 1'b0; step();
        check_val("bc_data", out_data, 64'h1234_1234_1234_AAAA);
        check_val("bc_upd", {60'd0, out_upd}, 64'hE);
        step();

        // Backpressure: only DEPTH beats fit, then in order release
        out_ready = 1'b0; w_en = 4'hF; in_valid = 1'b1;
        in_data = {4{16'h0001}}; step();
        in_data = {4{16'h0002}}; step();
        in_data = {4{16'h0003}}; #1;
        check_val("bp_in_ready", {63'd0, in_ready}, 64'd0);
        check_val("bp_head", out_data, {4{16'h0001}});
        step();
        check_val("bp_hold_head", out_data, {4{16'h0001}});
        out_ready = 1'b1; #1;
        check_val("bp_resume_rdy", {63'd0, in_ready}, 64'd1);
        step(); in_valid = 1'b0;
        check_val("bp_second", out_data, {4{16'h0002}});
        step();
        check_val("bp_third", out_data, {4{16'h0003}});
        step();
        check_val("bp_drained", {63'd0, out_valid}, 64'd0);

        // Clear mid-flight
        out_ready = 1'b0; w_en = 4'hF; in_valid = 1'b1;
        in_data = {$urandom, $urandom}; step();
        in_data = {$urandom, $urandom}; step();
        clr = 1'b1; #1;
        check_val("clr_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        check_val("clr_valid", {63'd0, out_valid}, 64'd0);
        check_val("clr_data", out_data, 64'd0);
        clr = 1'b0; out_ready = 1'b1;
        in_data = 64'h1111_2222_3333_0055; w_en = 4'b0001;
        step(); in_valid = 1'b0; step();
        check_val("clr_after", out_data, 64'h0000_0000_0000_0055);
        check_val("clr_after_upd", {60'd0, out_upd}, 64'h1);

        // Asynchronous reset mid-stream
        w_en = 4'hF; in_valid = 1'b1; in_data = {$urandom, $urandom};
        step(); step(); in_valid = 1'b0;
        rst_n = 1'b0; #1;
        check_val("rstm_valid", {63'd0, out_valid}, 64'd0);
        check_val("rstm_data", out_data, 64'd0);
        check_val("rstm_upd", {60'd0, out_upd}, 64'd0);
        check_val("rstm_in_ready", {63'd0, in_ready}, 64'd1);
        model_clear();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            w_en      = 4'($urandom);
            bcast     = ($urandom_range(0, 3) == 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
